// File: rtl/prm_scan_pkg.sv
// Shared defaults and FSM state type for the prm_edge_scan range scanner.
package prm_scan_pkg;

   localparam int QBITS_DEF  = 15;
   localparam int WORD_W_DEF = 32;
   localparam int LEN_W      = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_FLUSH,
      ST_DONE
   } scan_state_t;

endpackage

// File: rtl/prm_bit_packer.sv
// Packs sampled edge bits into WORD_W-bit words and holds each finished word
// in a valid/ready output register until the consumer takes it.
module prm_bit_packer
   import prm_scan_pkg::*;
#(
   parameter int QBITS  = QBITS_DEF,
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bit_valid,
   input  logic              bit_val,
   input  logic [QBITS-1:0]  bit_code,
   input  logic              flush,
   output logic              can_accept,
   output logic              empty,
   output logic [WORD_W-1:0] res_word,
   output logic [QBITS-1:0]  res_base,
   output logic [LEN_W-1:0]  res_len,
   output logic              res_valid,
   input  logic              res_ready
);

   localparam int CNT_W = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

   logic [WORD_W-1:0] pack_q, pack_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [QBITS-1:0]  base_q, base_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [QBITS-1:0]  obase_q, obase_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              valid_q, valid_d;
   logic              out_free;
   logic [QBITS-1:0]  cur_base;
   logic [WORD_W-1:0] pack_next;

   // The output register is free if empty or being drained this very cycle,
   // so a finished word can replace an accepted one without a bubble.
   assign out_free   = !valid_q || res_ready;
   assign can_accept = (cnt_q != LAST_IDX) || out_free;
   assign empty      = (cnt_q == '0) && !valid_q;
   assign cur_base   = (cnt_q == '0) ? bit_code : base_q;
   assign pack_next  = pack_q | (WORD_W'(bit_val) << cnt_q);

   always_comb begin
      pack_d  = pack_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      word_d  = word_q;
      obase_d = obase_q;
      len_d   = len_q;
      valid_d = valid_q;
      if (valid_q && res_ready) begin
         valid_d = 1'b0;
      end
      if (bit_valid) begin
         if (cnt_q == LAST_IDX) begin
            word_d  = pack_next;
            obase_d = cur_base;
            len_d   = LEN_W'(WORD_W);
            valid_d = 1'b1;
            pack_d  = '0;
            cnt_d   = '0;
         end else begin
            pack_d  = pack_next;
            cnt_d   = cnt_q + 1'b1;
            base_d  = cur_base;
         end
      end else if (flush && (cnt_q != '0) && out_free) begin
         word_d  = pack_q;
         obase_d = base_q;
         len_d   = LEN_W'(cnt_q);
         valid_d = 1'b1;
         pack_d  = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pack_q  <= '0;
         cnt_q   <= '0;
         base_q  <= '0;
         word_q  <= '0;
         obase_q <= '0;
         len_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         pack_q  <= pack_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         word_q  <= word_d;
         obase_q <= obase_d;
         len_q   <= len_d;
         valid_q <= valid_d;
      end
   end

   assign res_word  = word_q;
   assign res_base  = obase_q;
   assign res_len   = len_q;
   assign res_valid = valid_q;

endmodule

// File: rtl/prm_edge_scan.sv
// Walks an inclusive query range through an external edge checker and streams
// the answers as packed words. Define PRM_EDGE_SCAN_HITCNT_EN for hit_count.
module prm_edge_scan
   import prm_scan_pkg::*;
#(
   parameter int QBITS  = QBITS_DEF,
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [QBITS-1:0]  first_q,
   input  logic [QBITS-1:0]  last_q,
   output logic [QBITS-1:0]  q_code,
   output logic              q_valid,
   input  logic              edge_mask,
   output logic [WORD_W-1:0] res_word,
   output logic [QBITS-1:0]  res_base,
   output logic [LEN_W-1:0]  res_len,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              busy,
   output logic              done,
   output logic [15:0]       hit_count
);

   scan_state_t      state_q, state_d;
   logic [QBITS:0]   qry_q, qry_d;
   logic [QBITS-1:0] stop_q, stop_d;
   logic             can_accept;
   logic             pk_empty;
   logic             flush;
   logic             sample;

   // The query counter carries one extra bit so an all-ones stop code ends
   // the scan instead of wrapping back to zero.
   always_comb begin
      state_d = state_q;
      qry_d   = qry_q;
      stop_d  = stop_q;
      sample  = 1'b0;
      flush   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               stop_d  = last_q;
               qry_d   = {1'b0, first_q};
               state_d = (first_q > last_q) ? ST_DONE : ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (can_accept) begin
               sample = 1'b1;
               qry_d  = qry_q + 1'b1;
               if (qry_q == {1'b0, stop_q}) begin
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            flush = 1'b1;
            if (pk_empty) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         qry_q   <= '0;
         stop_q  <= '0;
      end else begin
         state_q <= state_d;
         qry_q   <= qry_d;
         stop_q  <= stop_d;
      end
   end

   assign q_valid = sample;
   assign q_code  = (state_q == ST_SCAN) ? qry_q[QBITS-1:0] : '0;
   assign busy    = (state_q == ST_SCAN) || (state_q == ST_FLUSH);
   assign done    = (state_q == ST_DONE);

   prm_bit_packer #(
      .QBITS  (QBITS),
      .WORD_W (WORD_W)
   ) u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_valid  (sample),
      .bit_val    (edge_mask),
      .bit_code   (qry_q[QBITS-1:0]),
      .flush      (flush),
      .can_accept (can_accept),
      .empty      (pk_empty),
      .res_word   (res_word),
      .res_base   (res_base),
      .res_len    (res_len),
      .res_valid  (res_valid),
      .res_ready  (res_ready)
   );

`ifdef PRM_EDGE_SCAN_HITCNT_EN
   logic [15:0] hit_q, hit_d;

   always_comb begin
      hit_d = hit_q;
      if ((state_q == ST_IDLE) && start) begin
         hit_d = '0;
      end else if (sample && edge_mask && (hit_q != 16'hFFFF)) begin
         hit_d = hit_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hit_q <= '0;
      end else begin
         hit_q <= hit_d;
      end
   end

   assign hit_count = hit_q;
`else
   assign hit_count = 16'd0;
`endif

endmodule

// File: tb/tb_prm_edge_scan.sv
// Directed and randomized self-checking bench for prm_edge_scan; expected
// words come from a chunking model of the range and a checker function.
module tb_prm_edge_scan;

   localparam int QBITS  = 15;
   localparam int WORD_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [QBITS-1:0]  first_q, last_q, q_code, res_base;
   logic              q_valid, edge_mask, res_valid, res_ready, busy, done;
   logic [WORD_W-1:0] res_word;
   logic [5:0]        res_len;
   logic [15:0]       hit_count;

   int               n_checks = 0;
   int               n_errors = 0;
   int               mask_mode;
   logic [QBITS-1:0] mask_key;

   logic [WORD_W-1:0] obs_word[$], exp_word[$];
   int                obs_base[$], exp_base[$], obs_len[$], exp_len[$];
   int                qcodes[$];
   int first_qv_cyc, done_cyc, done_pulses, busy_cycles, last_acc;
   int ovf_err, stable_err, stall_cnt, hold_err, zero_code_seen, rv_seen;
   int timed_out, exp_hits;

   always #5 clk = ~clk;

   function automatic logic mask_fn(input logic [QBITS-1:0] c, input int mode,
                                    input logic [QBITS-1:0] key);
      case (mode)
         0:       return ~c[0];
         1:       return 1'b1;
         default: return (^(c & key)) ^ c[2];
      endcase
   endfunction

   assign edge_mask = mask_fn(q_code, mask_mode, mask_key);

   prm_edge_scan #(.QBITS(QBITS), .WORD_W(WORD_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .first_q   (first_q),
      .last_q    (last_q),
      .q_code    (q_code),
      .q_valid   (q_valid),
      .edge_mask (edge_mask),
      .res_word  (res_word),
      .res_base  (res_base),
      .res_len   (res_len),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .busy      (busy),
      .done      (done),
      .hit_count (hit_count)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected stream: consecutive WORD_W-code chunks of the range, bit i of a
   // word is the checker answer for (base + i), last chunk may be short.
   task automatic buildExpected(input int first, input int last);
      logic [WORD_W-1:0] w;
      int len;
      int base;
      exp_word.delete(); exp_base.delete(); exp_len.delete();
      exp_hits = 0; w = '0; len = 0; base = first;
      for (int c = first; c <= last; c++) begin
         if (len == 0) base = c;
         if (mask_fn(QBITS'(c), mask_mode, mask_key)) begin
            w[len] = 1'b1;
            exp_hits++;
         end
         len++;
         if (len == WORD_W) begin
            exp_word.push_back(w); exp_base.push_back(base); exp_len.push_back(len);
            w = '0; len = 0;
         end
      end
      if (len != 0) begin
         exp_word.push_back(w); exp_base.push_back(base); exp_len.push_back(len);
      end
   endtask

   // rmode: 0 ready always, 1 random ready, 2 hold ready low for 20 stall cycles
   // after the first word. rst_code >= 0 pulls rst_n low at that query.
   task automatic applyStimulus(input int first, input int last, input int rmode, input int rst_code);
      logic              pv, pr;
      logic [WORD_W-1:0] pw;
      logic [QBITS-1:0]  pb;
      logic [5:0]        pl;
      int sp, low_cycles, n_total;
      bit rst_hit;
      obs_word.delete(); obs_base.delete(); obs_len.delete(); qcodes.delete();
      first_qv_cyc = -1; done_cyc = -1; done_pulses = 0; busy_cycles = 0;
      last_acc = -100; ovf_err = 0; stable_err = 0; stall_cnt = 0; hold_err = 0;
      zero_code_seen = 0; rv_seen = 0; timed_out = 0;
      pv = 1'b0; pr = 1'b0; pw = '0; pb = '0; pl = '0;
      sp = 0; low_cycles = 0; rst_hit = 0;
      n_total = (last >= first) ? last - first + 1 : 0;
      @(negedge clk);
      first_q = QBITS'(first); last_q = QBITS'(last); start = 1'b1; res_ready = 1'b1;
      for (int cyc = 1; cyc <= 3000; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         case (rmode)
            0:       res_ready = 1'b1;
            1:       res_ready = ($urandom_range(0, 3) != 0);
            default: res_ready = (sp != 1);
         endcase
         #1;
         if (q_valid) begin
            if (qcodes.size() == 0) first_qv_cyc = cyc;
            else if (q_code == '0) zero_code_seen++;
            if (((qcodes.size() % WORD_W) == WORD_W - 1) && res_valid && !res_ready) ovf_err++;
            qcodes.push_back(int'(q_code));
         end
         if (pv && !pr && (!res_valid || res_word !== pw || res_base !== pb || res_len !== pl))
            stable_err++;
         if (res_valid) rv_seen = 1;
         if (res_valid && res_ready) begin
            obs_word.push_back(res_word); obs_base.push_back(int'(res_base));
            obs_len.push_back(int'(res_len)); last_acc = cyc;
         end
         pv = res_valid; pr = res_ready; pw = res_word; pb = res_base; pl = res_len;
         if (busy) busy_cycles++;
         if (done) begin
            done_pulses++;
            done_cyc = cyc;
         end
         if (rmode == 2) begin
            if (sp == 0 && res_valid) begin
               sp = 1;
            end else if (sp == 1) begin
               low_cycles++;
               if (busy && !q_valid && qcodes.size() < n_total) begin
                  stall_cnt++;
                  if (q_code !== QBITS'(first + qcodes.size())) hold_err++;
               end
               if (stall_cnt >= 20 || low_cycles >= 300) sp = 2;
            end
         end
         if (rst_code >= 0 && q_valid && int'(q_code) == rst_code) begin
            rst_n = 1'b0;
            rst_hit = 1;
            break;
         end
         if (done_pulses > 0 && cyc > done_cyc) break;
      end
      if (!rst_hit && done_pulses == 0) timed_out = 1;
   endtask

   task automatic verifyScan(input string tag, input int first, input int last);
      int seq_err;
      int n_total;
      n_total = (last >= first) ? last - first + 1 : 0;
      seq_err = 0;
      for (int i = 0; i < qcodes.size(); i++)
         if (qcodes[i] != first + i) seq_err++;
      checkOutput({tag, "_timeout"}, timed_out, 0);
      checkOutput({tag, "_nqueries"}, qcodes.size(), n_total);
      checkOutput({tag, "_qorder"}, seq_err, 0);
      checkOutput({tag, "_first_qv_cyc"}, first_qv_cyc, (n_total > 0) ? 1 : -1);
      checkOutput({tag, "_nwords"}, obs_word.size(), exp_word.size());
      for (int i = 0; i < exp_word.size() && i < obs_word.size(); i++) begin
         checkOutput($sformatf("%s_word%0d", tag, i), obs_word[i], exp_word[i]);
         checkOutput($sformatf("%s_base%0d", tag, i), obs_base[i], exp_base[i]);
         checkOutput($sformatf("%s_len%0d", tag, i), obs_len[i], exp_len[i]);
      end
      checkOutput({tag, "_rv_seen"}, rv_seen, (exp_word.size() > 0) ? 1 : 0);
      checkOutput({tag, "_done_cyc"}, done_cyc, (n_total == 0) ? 1 : last_acc + 2);
      checkOutput({tag, "_done_pulses"}, done_pulses, 1);
      checkOutput({tag, "_busy_cycles"}, busy_cycles, done_cyc - 1);
      checkOutput({tag, "_overflow"}, ovf_err, 0);
      checkOutput({tag, "_stable"}, stable_err, 0);
`ifdef PRM_EDGE_SCAN_HITCNT_EN
      checkOutput({tag, "_hits"}, hit_count, (exp_hits > 65535) ? 65535 : exp_hits);
`else
      checkOutput({tag, "_hits"}, hit_count, 0);
`endif
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; first_q = '0; last_q = '0; res_ready = 1'b0;
      mask_mode = 0; mask_key = '0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_q_valid", q_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_res_valid", res_valid, 0);
      checkOutput("rst_hit_count", hit_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] even codes 0..31");
      mask_mode = 0;
      applyStimulus(0, 31, 0, -1);
      buildExpected(0, 31);
      verifyScan("even32", 0, 31);
      checkOutput("even32_literal", (obs_word.size() > 0) ? obs_word[0] : '0, 32'h5555_5555);

      $display("[TB] top of code space 0x7FF0..0x7FFF");
      mask_mode = 2; mask_key = QBITS'($urandom);
      applyStimulus(32'h7FF0, 32'h7FFF, 0, -1);
      buildExpected(32'h7FF0, 32'h7FFF);
      verifyScan("top", 32'h7FF0, 32'h7FFF);
      checkOutput("top_last_code", (qcodes.size() > 0) ? qcodes[qcodes.size()-1] : -1, 32'h7FFF);
      checkOutput("top_no_wrap", zero_code_seen, 0);
      checkOutput("top_upper_zero", (obs_word.size() > 0) ? obs_word[0][31:16] : 16'hDEAD, 0);

      $display("[TB] 0..95 with consumer stall");
      mask_key = QBITS'($urandom);
      applyStimulus(0, 95, 2, -1);
      buildExpected(0, 95);
      verifyScan("stall", 0, 95);
      checkOutput("stall_cycles", stall_cnt, 20);
      checkOutput("stall_code_held", hold_err, 0);

      $display("[TB] empty range 10..5");
      applyStimulus(10, 5, 0, -1);
      buildExpected(10, 5);
      verifyScan("empty", 10, 5);

      $display("[TB] reset in the middle of 0..127");
      mask_mode = 1;
      applyStimulus(0, 127, 0, 39);
      @(negedge clk);
      #1;
      checkOutput("midrst_q_valid", q_valid, 0);
      checkOutput("midrst_q_code", q_code, 0);
      checkOutput("midrst_res_valid", res_valid, 0);
      checkOutput("midrst_res_word", res_word, 0);
      checkOutput("midrst_res_base", res_base, 0);
      checkOutput("midrst_res_len", res_len, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_done", done, 0);
      checkOutput("midrst_hit_count", hit_count, 0);
      rst_n = 1'b1;
      mask_mode = 2; mask_key = QBITS'($urandom);
      applyStimulus(0, 3, 0, -1);
      buildExpected(0, 3);
      verifyScan("after_rst", 0, 3);
      checkOutput("after_rst_len4", (obs_len.size() > 0) ? obs_len[0] : -1, 4);

      $display("[TB] all hits 0..99");
      mask_mode = 1;
      applyStimulus(0, 99, 1, -1);
      buildExpected(0, 99);
      verifyScan("hits", 0, 99);
`ifdef PRM_EDGE_SCAN_HITCNT_EN
      checkOutput("hits_100", hit_count, 100);
`else
      checkOutput("hits_100", hit_count, 0);
`endif

      $display("[TB] randomized ranges");
      for (int r = 0; r < 6; r++) begin
         int f, l;
         f = int'($urandom_range(0, 32767));
         l = f + int'($urandom_range(0, 89));
         if (l > 32767) l = 32767;
         mask_mode = 2; mask_key = QBITS'($urandom);
         applyStimulus(f, l, 1, -1);
         buildExpected(f, l);
         verifyScan($sformatf("rand%0d", r), f, l);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
